// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, decode classes,
// ALU operation codes, instruction field encodings and control-field encodings.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEMACC, S_WBACK, S_BRANCH, S_JUMP, S_EXCPT
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR
    } class_e;

    localparam int unsigned ALU_CODE_W = 5;
    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_XOR = 5'd5;
    localparam logic [4:0] ALU_NOR = 5'd6;
    localparam logic [4:0] ALU_SLT = 5'd7;
    localparam logic [4:0] ALU_SLL = 5'd8;
    localparam logic [4:0] ALU_SRL = 5'd9;
    localparam logic [4:0] ALU_SRA = 5'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [1:0] SRC_RT    = 2'b00;
    localparam logic [1:0] SRC_SHAMT = 2'b01;
    localparam logic [1:0] SRC_ZEXT  = 2'b10;
    localparam logic [1:0] SRC_SEXT  = 2'b11;
    localparam logic [1:0] DST_RD    = 2'b00;
    localparam logic [1:0] DST_RT    = 2'b01;
    localparam logic [1:0] DST_R31   = 2'b10;
    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BR     = 2'b01;
    localparam logic [1:0] PC_JMP    = 2'b10;
    localparam logic [1:0] PC_EXC    = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;
    localparam logic [1:0] CAUSE_IRQ     = 2'b11;

endpackage

// File: rtl/mc_dec.sv
// Combinational instruction decoder: maps op_code/funct to legality, class and
// the per-instruction datapath selects used by EXEC and WBACK.
module mc_dec
    import mc_pkg::*;
(
    input  logic [5:0]            op_code_i,
    input  logic [5:0]            funct_i,
    output logic                  legal_o,
    output class_e                class_o,
    output logic [ALU_CODE_W-1:0] alu_op_o,
    output logic [1:0]            alu_src_o,
    output logic [1:0]            reg_dst_o,
    output logic [1:0]            wb_sel_o
);

    always_comb begin
        legal_o   = 1'b1;
        class_o   = CL_ALU;
        alu_op_o  = ALU_NOP;
        alu_src_o = SRC_RT;
        reg_dst_o = DST_RD;
        wb_sel_o  = WB_ALU;
        case (op_code_i)
            OP_RTYPE: begin
                case (funct_i)
                    F_ADD: alu_op_o = ALU_ADD;
                    F_SUB: alu_op_o = ALU_SUB;
                    F_AND: alu_op_o = ALU_AND;
                    F_OR:  alu_op_o = ALU_OR;
                    F_XOR: alu_op_o = ALU_XOR;
                    F_NOR: alu_op_o = ALU_NOR;
                    F_SLT: alu_op_o = ALU_SLT;
                    F_SLL: begin alu_op_o = ALU_SLL; alu_src_o = SRC_SHAMT; end
                    F_SRL: begin alu_op_o = ALU_SRL; alu_src_o = SRC_SHAMT; end
                    F_SRA: begin alu_op_o = ALU_SRA; alu_src_o = SRC_SHAMT; end
                    F_JR:  class_o = CL_JR;
                    default: legal_o = 1'b0;
                endcase
            end
            OP_ADDI: begin alu_op_o = ALU_ADD; alu_src_o = SRC_SEXT; reg_dst_o = DST_RT; end
            OP_ANDI: begin alu_op_o = ALU_AND; alu_src_o = SRC_ZEXT; reg_dst_o = DST_RT; end
            OP_ORI:  begin alu_op_o = ALU_OR;  alu_src_o = SRC_ZEXT; reg_dst_o = DST_RT; end
            OP_XORI: begin alu_op_o = ALU_XOR; alu_src_o = SRC_ZEXT; reg_dst_o = DST_RT; end
            OP_LW: begin
                class_o   = CL_LOAD;
                alu_op_o  = ALU_ADD;
                alu_src_o = SRC_SEXT;
                reg_dst_o = DST_RT;
                wb_sel_o  = WB_MEM;
            end
            OP_SW: begin class_o = CL_STORE; alu_op_o = ALU_ADD; alu_src_o = SRC_SEXT; end
            OP_BEQ: begin class_o = CL_BEQ; alu_op_o = ALU_SUB; end
            OP_BNE: begin class_o = CL_BNE; alu_op_o = ALU_SUB; end
            OP_J:   class_o = CL_J;
            OP_JAL: begin class_o = CL_JAL; reg_dst_o = DST_R31; wb_sel_o = WB_PC4; end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctl.sv
// Multi-cycle CPU controller: state register, memory wait counter with bus
// timeout, exception cause register and per-state control output sequencing.
module mc_ctl
    import mc_pkg::*;
#(
    parameter int unsigned ALUOP_W = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op_code,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               irq,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               a_sel,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         wb_sel,
    output logic               epc_write,
    output logic [1:0]         cause
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e                  state_q, state_d;
    logic [7:0]              wait_q, wait_d;
    logic [1:0]              cause_q, cause_d;
    logic [ALU_CODE_W-1:0]   alu_op_c;
    logic                    dec_legal;
    class_e                  dec_class;
    logic [ALU_CODE_W-1:0]   dec_alu_op;
    logic [1:0]              dec_alu_src, dec_reg_dst, dec_wb_sel;
    logic                    timed_out;

    mc_dec u_dec (
        .op_code_i (op_code),
        .funct_i   (funct),
        .legal_o   (dec_legal),
        .class_o   (dec_class),
        .alu_op_o  (dec_alu_op),
        .alu_src_o (dec_alu_src),
        .reg_dst_o (dec_reg_dst),
        .wb_sel_o  (dec_wb_sel)
    );

    assign timed_out = (wait_q == TIMEOUT_C);
    assign alu_op    = ALUOP_W'(alu_op_c);

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SEQ;
        a_sel     = 1'b0;
        reg_write = 1'b0;
        reg_dst   = DST_RD;
        alu_src   = SRC_RT;
        alu_op_c  = ALU_NOP;
        wb_sel    = WB_ALU;
        epc_write = 1'b0;
        case (state_q)
            S_FETCH: begin
                // The wait counter is zero only on the first FETCH cycle.
                if (irq && wait_q == '0) begin
                    state_d = S_EXCPT;
                    cause_d = CAUSE_IRQ;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timed_out) begin
                        state_d = S_EXCPT;
                        cause_d = CAUSE_BUS;
                    end
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d = S_EXCPT;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    case (dec_class)
                        CL_BEQ, CL_BNE:      state_d = S_BRANCH;
                        CL_J, CL_JAL, CL_JR: state_d = S_JUMP;
                        default:             state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                alu_op_c = dec_alu_op;
                alu_src  = dec_alu_src;
                state_d  = (dec_class == CL_LOAD || dec_class == CL_STORE) ? S_MEMACC : S_WBACK;
            end
            S_MEMACC: begin
                mem_req = 1'b1;
                mem_we  = (dec_class == CL_STORE);
                if (mem_ready) begin
                    state_d = (dec_class == CL_STORE) ? S_FETCH : S_WBACK;
                end else if (timed_out) begin
                    state_d = S_EXCPT;
                    cause_d = CAUSE_BUS;
                end
            end
            S_WBACK: begin
                reg_write = 1'b1;
                reg_dst   = dec_reg_dst;
                wb_sel    = dec_wb_sel;
                alu_op_c  = dec_alu_op;
                alu_src   = dec_alu_src;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op_c = ALU_SUB;
                pc_write = (dec_class == CL_BEQ) ? zero : ~zero;
                pc_src   = PC_BR;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JMP;
                a_sel    = (dec_class == CL_JR);
                if (dec_class == CL_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = DST_R31;
                    wb_sel    = WB_PC4;
                end
                state_d = S_FETCH;
            end
            S_EXCPT: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = PC_EXC;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_req && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end

        cause = cause_q;
        // Reset forces every output low combinationally, even mid-access.
        if (!reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = '0;
            a_sel     = 1'b0;
            reg_write = 1'b0;
            reg_dst   = '0;
            alu_src   = '0;
            alu_op_c  = '0;
            wb_sel    = '0;
            epc_write = 1'b0;
            cause     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_mc_ctl.sv
// Self-checking bench for mc_ctl: directed vector table, hand-written timeout and
// reset sequences, then random instruction streams against a transaction-level model.
module tb_mc_ctl;
    import mc_pkg::*;

    localparam int unsigned TO = 3;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4,
                   K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

    logic       clk = 1'b0;
    logic       reset, zero, irq, mem_ready;
    logic [5:0] op_code, funct;
    logic       mem_req, mem_we, ir_write, pc_write, a_sel, reg_write, epc_write;
    logic [1:0] pc_src, reg_dst, alu_src, wb_sel, cause;
    logic [4:0] alu_op;

    always #5 clk = ~clk;

    mc_ctl #(.ALUOP_W(5), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .funct(funct), .zero(zero),
        .irq(irq), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .a_sel(a_sel),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
        .wb_sel(wb_sel), .epc_write(epc_write), .cause(cause)
    );

    typedef struct packed {
        logic       mreq, mwe, irw, pcw;
        logic [1:0] psrc;
        logic       asel, rw;
        logic [1:0] rdst, asrc;
        logic [4:0] aop;
        logic [1:0] wbs;
        logic       epc;
        logic [1:0] cs;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op, fn;
        logic       zero, irq, rdy;
        out_t       exp;
    } vec_t;

    typedef struct {
        logic [5:0] op, fn;
        int         kind;
        logic [4:0] aop;
        logic [1:0] asrc, rdst, wbs;
    } ins_t;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] m_cause;
    vec_t       dir[$];
    vec_t       rq[$];
    ins_t       itab[$];

    function automatic out_t O(
        input logic mreq = 1'b0, input logic mwe = 1'b0, input logic irw = 1'b0,
        input logic pcw = 1'b0, input logic [1:0] psrc = 2'd0, input logic asel = 1'b0,
        input logic rw = 1'b0, input logic [1:0] rdst = 2'd0, input logic [1:0] asrc = 2'd0,
        input logic [4:0] aop = 5'd0, input logic [1:0] wbs = 2'd0, input logic epc = 1'b0,
        input logic [1:0] cs = 2'd0);
        out_t o;
        o.mreq = mreq; o.mwe = mwe; o.irw = irw; o.pcw = pcw; o.psrc = psrc;
        o.asel = asel; o.rw = rw; o.rdst = rdst; o.asrc = asrc; o.aop = aop;
        o.wbs = wbs; o.epc = epc; o.cs = cs;
        return o;
    endfunction

    function automatic vec_t V(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic iq, input logic rdy, input out_t e);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.zero = z; v.irq = iq; v.rdy = rdy; v.exp = e;
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic step(input vec_t v, input string nm);
        out_t act;
        reset = v.rst; op_code = v.op; funct = v.fn;
        zero = v.zero; irq = v.irq; mem_ready = v.rdy;
        @(negedge clk);
        act = out_t'({mem_req, mem_we, ir_write, pc_write, pc_src, a_sel, reg_write,
                      reg_dst, alu_src, alu_op, wb_sel, epc_write, cause});
        checks++;
        if (act !== v.exp) begin
            failures++;
            $display("FAIL %s check#%0d got=%h want=%h", nm, checks, act, v.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add_ins(input logic [5:0] op, input logic [5:0] fn, input int kind,
                           input logic [4:0] aop, input logic [1:0] asrc,
                           input logic [1:0] rdst, input logic [1:0] wbs);
        ins_t t;
        t.op = op; t.fn = fn; t.kind = kind; t.aop = aop;
        t.asrc = asrc; t.rdst = rdst; t.wbs = wbs;
        itab.push_back(t);
    endtask

    task automatic push_row(input ins_t in, input logic z, input logic iq, input logic rdy,
                            input out_t e);
        rq.push_back(V(1'b1, in.op, in.fn, z, iq, rdy, e));
    endtask

    task automatic excpt(input ins_t in, input logic [1:0] c);
        m_cause = c;
        push_row(in, rb(), rb(), rb(), O(.epc(1'b1), .pcw(1'b1), .psrc(2'd3), .cs(c)));
    endtask

    // Memory phase: w not-ready cycles before ready; past TO the bus faults.
    task automatic mem_phase(input ins_t in, input int unsigned w, input bit fetch,
                             input logic we, output bit ok);
        int unsigned nw;
        nw = (w > TO) ? TO + 1 : w;
        for (int unsigned k = 0; k < nw; k++)
            push_row(in, rb(), (fetch && k == 0) ? 1'b0 : rb(), 1'b0,
                     O(.mreq(1'b1), .mwe(we), .cs(m_cause)));
        if (w > TO) begin
            excpt(in, CAUSE_BUS);
            ok = 1'b0;
        end else begin
            push_row(in, rb(), (fetch && nw == 0) ? 1'b0 : rb(), 1'b1,
                     O(.mreq(1'b1), .mwe(we), .irw(fetch), .pcw(fetch), .cs(m_cause)));
            ok = 1'b1;
        end
    endtask

    task automatic gen_instr();
        ins_t in;
        bit   ok;
        logic z;
        in = itab[$urandom_range(itab.size() - 1)];
        if (in.op != 6'h00) in.fn = 6'($urandom);
        if ($urandom_range(9) == 0) begin
            push_row(in, rb(), 1'b1, rb(), O(.cs(m_cause)));
            excpt(in, CAUSE_IRQ);
            return;
        end
        mem_phase(in, $urandom_range(TO + 1), 1'b1, 1'b0, ok);
        if (!ok) return;
        push_row(in, rb(), rb(), rb(), O(.cs(m_cause)));
        if (in.kind == K_ILL) begin
            excpt(in, CAUSE_ILLEGAL);
            return;
        end
        case (in.kind)
            K_ALU, K_LW, K_SW: begin
                push_row(in, rb(), rb(), rb(), O(.aop(in.aop), .asrc(in.asrc), .cs(m_cause)));
                ok = 1'b1;
                if (in.kind != K_ALU)
                    mem_phase(in, $urandom_range(TO + 1), 1'b0, in.kind == K_SW, ok);
                if (ok && in.kind != K_SW)
                    push_row(in, rb(), rb(), rb(), O(.rw(1'b1), .rdst(in.rdst), .wbs(in.wbs),
                             .aop(in.aop), .asrc(in.asrc), .cs(m_cause)));
            end
            K_BEQ, K_BNE: begin
                z = rb();
                push_row(in, z, rb(), rb(), O(.aop(ALU_SUB), .psrc(2'd1),
                         .pcw((in.kind == K_BEQ) ? z : ~z), .cs(m_cause)));
            end
            default: begin
                push_row(in, rb(), rb(), rb(), O(.pcw(1'b1), .psrc(2'd2),
                         .asel(in.kind == K_JR), .rw(in.kind == K_JAL),
                         .rdst((in.kind == K_JAL) ? 2'd2 : 2'd0),
                         .wbs((in.kind == K_JAL) ? 2'd2 : 2'd0), .cs(m_cause)));
            end
        endcase
    endtask

    initial begin
        reset = 1'b0; op_code = '0; funct = '0; zero = 1'b0; irq = 1'b0; mem_ready = 1'b0;

        add_ins(6'h00, 6'h20, K_ALU, ALU_ADD, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h22, K_ALU, ALU_SUB, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h24, K_ALU, ALU_AND, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h25, K_ALU, ALU_OR,  2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h26, K_ALU, ALU_XOR, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h27, K_ALU, ALU_NOR, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h2A, K_ALU, ALU_SLT, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h00, K_ALU, ALU_SLL, 2'd1, 2'd0, 2'd0);
        add_ins(6'h00, 6'h02, K_ALU, ALU_SRL, 2'd1, 2'd0, 2'd0);
        add_ins(6'h00, 6'h03, K_ALU, ALU_SRA, 2'd1, 2'd0, 2'd0);
        add_ins(6'h00, 6'h08, K_JR,  ALU_NOP, 2'd0, 2'd0, 2'd0);
        add_ins(6'h08, 6'h00, K_ALU, ALU_ADD, 2'd3, 2'd1, 2'd0);
        add_ins(6'h0C, 6'h00, K_ALU, ALU_AND, 2'd2, 2'd1, 2'd0);
        add_ins(6'h0D, 6'h00, K_ALU, ALU_OR,  2'd2, 2'd1, 2'd0);
        add_ins(6'h0E, 6'h00, K_ALU, ALU_XOR, 2'd2, 2'd1, 2'd0);
        add_ins(6'h23, 6'h00, K_LW,  ALU_ADD, 2'd3, 2'd1, 2'd1);
        add_ins(6'h2B, 6'h00, K_SW,  ALU_ADD, 2'd3, 2'd0, 2'd0);
        add_ins(6'h04, 6'h00, K_BEQ, ALU_SUB, 2'd0, 2'd0, 2'd0);
        add_ins(6'h05, 6'h00, K_BNE, ALU_SUB, 2'd0, 2'd0, 2'd0);
        add_ins(6'h02, 6'h00, K_J,   ALU_NOP, 2'd0, 2'd0, 2'd0);
        add_ins(6'h03, 6'h00, K_JAL, ALU_NOP, 2'd0, 2'd0, 2'd0);
        add_ins(6'h3F, 6'h00, K_ILL, ALU_NOP, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h01, K_ILL, ALU_NOP, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h21, K_ILL, ALU_NOP, 2'd0, 2'd0, 2'd0);
        add_ins(6'h00, 6'h09, K_ILL, ALU_NOP, 2'd0, 2'd0, 2'd0);
        add_ins(6'h10, 6'h00, K_ILL, ALU_NOP, 2'd0, 2'd0, 2'd0);
        add_ins(6'h0A, 6'h00, K_ILL, ALU_NOP, 2'd0, 2'd0, 2'd0);

        // Directed table: reset, add, beq both ways, illegal, late lw, irq, jal, jr.
        dir.push_back(V(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, O()));
        dir.push_back(V(1'b0, 6'h00, 6'h20, 1'b1, 1'b1, 1'b1, O()));
        dir.push_back(V(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1))));
        dir.push_back(V(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, O()));
        dir.push_back(V(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, O(.aop(ALU_ADD))));
        dir.push_back(V(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, O(.rw(1'b1), .aop(ALU_ADD))));
        dir.push_back(V(1'b1, 6'h04, 6'h00, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1))));
        dir.push_back(V(1'b1, 6'h04, 6'h00, 1'b0, 1'b0, 1'b1, O()));
        dir.push_back(V(1'b1, 6'h04, 6'h00, 1'b0, 1'b0, 1'b1, O(.aop(ALU_SUB), .psrc(2'd1))));
        dir.push_back(V(1'b1, 6'h04, 6'h00, 1'b1, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1))));
        dir.push_back(V(1'b1, 6'h04, 6'h00, 1'b1, 1'b0, 1'b1, O()));
        dir.push_back(V(1'b1, 6'h04, 6'h00, 1'b1, 1'b0, 1'b1, O(.aop(ALU_SUB), .psrc(2'd1), .pcw(1'b1))));
        dir.push_back(V(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1))));
        dir.push_back(V(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, O()));
        dir.push_back(V(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, O(.epc(1'b1), .pcw(1'b1), .psrc(2'd3), .cs(2'd1))));
        dir.push_back(V(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1), .cs(2'd1))));
        dir.push_back(V(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, O(.cs(2'd1))));
        dir.push_back(V(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, O(.aop(ALU_ADD), .asrc(2'd3), .cs(2'd1))));
        dir.push_back(V(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, O(.mreq(1'b1), .cs(2'd1))));
        dir.push_back(V(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, O(.mreq(1'b1), .cs(2'd1))));
        dir.push_back(V(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .cs(2'd1))));
        dir.push_back(V(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, O(.rw(1'b1), .rdst(2'd1), .wbs(2'd1),
                                                              .aop(ALU_ADD), .asrc(2'd3), .cs(2'd1))));
        dir.push_back(V(1'b1, 6'h03, 6'h00, 1'b0, 1'b1, 1'b1, O(.cs(2'd1))));
        dir.push_back(V(1'b1, 6'h03, 6'h00, 1'b0, 1'b1, 1'b1, O(.epc(1'b1), .pcw(1'b1), .psrc(2'd3), .cs(2'd3))));
        dir.push_back(V(1'b1, 6'h03, 6'h00, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1), .cs(2'd3))));
        dir.push_back(V(1'b1, 6'h03, 6'h00, 1'b0, 1'b1, 1'b1, O(.cs(2'd3))));
        dir.push_back(V(1'b1, 6'h03, 6'h00, 1'b0, 1'b1, 1'b1, O(.pcw(1'b1), .psrc(2'd2), .rw(1'b1),
                                                              .rdst(2'd2), .wbs(2'd2), .cs(2'd3))));
        dir.push_back(V(1'b1, 6'h00, 6'h08, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1), .cs(2'd3))));
        dir.push_back(V(1'b1, 6'h00, 6'h08, 1'b0, 1'b0, 1'b1, O(.cs(2'd3))));
        dir.push_back(V(1'b1, 6'h00, 6'h08, 1'b0, 1'b0, 1'b1, O(.pcw(1'b1), .psrc(2'd2), .asel(1'b1), .cs(2'd3))));

        @(posedge clk);
        #1;
        for (int i = 0; i < dir.size(); i++) step(dir[i], "dir");

        // Fetch ready exactly when the counter hits TO is still accepted; late irq ignored.
        for (int unsigned k = 0; k < TO; k++)
            step(V(1'b1, 6'h02, 6'h00, 1'b0, (k != 0), 1'b0, O(.mreq(1'b1), .cs(2'd3))), "fetch_wait");
        step(V(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1), .cs(2'd3))), "fetch_edge");
        step(V(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b0, O(.cs(2'd3))), "j_dec");
        step(V(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b0, O(.pcw(1'b1), .psrc(2'd2), .cs(2'd3))), "j_jump");

        // sw whose memory never answers: TO wait cycles, one decision cycle, then EXCPT.
        step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1), .cs(2'd3))), "sw_fetch");
        step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, O(.cs(2'd3))), "sw_dec");
        step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, O(.aop(ALU_ADD), .asrc(2'd3), .cs(2'd3))), "sw_exec");
        for (int unsigned k = 0; k <= TO; k++)
            step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, O(.mreq(1'b1), .mwe(1'b1), .cs(2'd3))), "sw_wait");
        step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, O(.epc(1'b1), .pcw(1'b1), .psrc(2'd3), .cs(2'd2))), "bus_excpt");

        // Reset asserted in MEMACC of sw: outputs drop at once, fetch resumes on release.
        step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1), .cs(2'd2))), "rs_fetch");
        step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, O(.cs(2'd2))), "rs_dec");
        step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, O(.aop(ALU_ADD), .asrc(2'd3), .cs(2'd2))), "rs_exec");
        step(V(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, O(.mreq(1'b1), .mwe(1'b1), .cs(2'd2))), "rs_mem");
        step(V(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, O()), "rs_assert");
        step(V(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, O()), "rs_hold");
        step(V(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b1, O(.mreq(1'b1), .irw(1'b1), .pcw(1'b1))), "rs_refetch");
        step(V(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b1, O()), "rs_dec2");
        step(V(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b1, O(.pcw(1'b1), .psrc(2'd2))), "rs_jump");

        m_cause = CAUSE_NONE;
        for (int n = 0; n < 300; n++) gen_instr();
        for (int i = 0; i < rq.size(); i++) step(rq[i], "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
